health_exec_ctrl: RTL and testbench
===================================

HEALTH_EXEC_CTRL -- requirements
Module: health_exec_ctrl

Interface
REQ-001 SHALL have parameter USER_BITS, default 5, width of the user index (2**USER_BITS user slots).
REQ-002 SHALL have parameter ALU_TIMEOUT, default 64, the maximum number of cycles allowed in WAIT before the operation aborts.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports: clk in 1, rising-edge clock; reset in 1, async active-high.
REQ-004 SHALL have port in_valid  in  1  decoded instruction present.
REQ-005 SHALL have port in_ready  out  1  controller accepts instruction.
REQ-006 SHALL have ports is_set_height, is_set_weight, is_calc_bmi, is_calc_bmr  in  1 each  decoder strobes, qualified by in_valid.
REQ-007 SHALL have ports rd  in  USER_BITS  user index; imm_ext  in  32  sign-extended immediate; funct7  in  7  gender[6], age[5:0].
REQ-008 SHALL have ports mem_we_height, mem_we_weight  out  1  memory write strobes; mem_index  out  USER_BITS; mem_wdata  out  32.
REQ-009 SHALL have ports alu_start  out  1  one-cycle launch pulse; alu_sel_bmr  out  1  (0=BMI, 1=BMR); alu_funct7  out  7; alu_done  in  1; alu_result  in  32.
REQ-010 SHALL have ports res_valid  out  1; res_ready  in  1; res_data  out  32; res_err  out  1.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, CHECK, LAUNCH, WAIT, RESP.
REQ-013 SHALL drive in_ready=1 only in IDLE; an instruction is accepted on in_valid&&in_ready, and rd, imm_ext, funct7 and the strobes are registered at acceptance.
REQ-014 SHALL treat an accepted instruction with zero or more than one strobe set as illegal: go to RESP with res_err=1, res_data=1.
REQ-015 SHALL, for set_height or set_weight, go IDLE->WRITE and in WRITE assert the matching mem_we for exactly one cycle, with mem_index=rd and mem_wdata=imm_ext.
REQ-016 SHALL, in WRITE, set the matching per-user scoreboard bit (height_ok[rd] or weight_ok[rd]) and return to IDLE with no response.
REQ-017 SHALL, for calc_bmi or calc_bmr, go IDLE->CHECK, and in CHECK proceed to LAUNCH only if both height_ok[rd] and weight_ok[rd] are set; otherwise go to RESP with res_err=1, res_data=2.
REQ-018 SHALL, in LAUNCH, pulse alu_start for one cycle with alu_sel_bmr and alu_funct7 driven from the registered values, drive mem_index=rd, and go to WAIT.
REQ-019 SHALL hold mem_index, alu_sel_bmr and alu_funct7 stable from LAUNCH through WAIT.
REQ-020 SHALL, in WAIT, count cycles from 1; on alu_done, capture alu_result into res_data with res_err=0 and go to RESP.
REQ-021 SHALL, if the WAIT count reaches ALU_TIMEOUT without alu_done, go to RESP with res_err=1, res_data=3.
REQ-022 SHALL, if alu_done and timeout occur in the same cycle, treat the operation as done (alu_done wins).
REQ-023 SHALL ignore alu_done in every state other than WAIT.
REQ-024 SHALL, in RESP, assert res_valid and hold res_data and res_err stable until res_ready; on res_valid&&res_ready go to IDLE.
REQ-025 SHALL give a minimum latency of 4 cycles from acceptance to res_valid for a successful calc with alu_done arriving the cycle after alu_start.
REQ-026 SHALL keep mem_we_* and alu_start low outside WRITE and LAUNCH respectively.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, clear all scoreboard bits, and drive in_ready=1, busy=0, res_valid=0, res_err=0, res_data=0, alu_start=0, mem_we_*=0, mem_index=0, mem_wdata=0, alu_sel_bmr=0, alu_funct7=0.
REQ-028 SHALL abandon any in-flight operation (including WAIT or RESP) on reset, with no response emitted.

Verification
REQ-029 SHALL be verified by: set_height rd=3 imm=170 -> mem_we_height pulses 1 cycle, mem_index=3, mem_wdata=170, no res_valid.
REQ-030 SHALL be verified by: set_height and set_weight for rd=3, then calc_bmi rd=3, alu_done one cycle after alu_start with alu_result=22 -> res_valid, res_data=22, res_err=0, held until res_ready.
REQ-031 SHALL be verified by: calc_bmr rd=7 with only height set -> alu_start never pulses, res_err=1, res_data=2.
REQ-032 SHALL be verified by: in_valid with is_calc_bmi and is_set_weight both set -> res_err=1, res_data=1.
REQ-033 SHALL be verified by: valid calc with alu_done withheld -> res_err=1, res_data=3 exactly ALU_TIMEOUT cycles after entering WAIT; alu_done on the final cycle -> success instead.
REQ-034 SHALL be verified by: reset asserted during WAIT -> outputs at reset values immediately, scoreboard cleared, and a subsequent calc for the same rd returns res_data=2.

Source files
------------

// File: rtl/health_exec_ctrl_if.sv
// Instruction, memory-write, ALU and response signals of the health execution controller.
// The slave modport is the controller; the master modport is the surrounding pipeline.
interface health_exec_ctrl_if #(
  parameter int USER_BITS = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_set_height;
  logic                 is_set_weight;
  logic                 is_calc_bmi;
  logic                 is_calc_bmr;
  logic [USER_BITS-1:0] rd;
  logic [31:0]          imm_ext;
  logic [6:0]           funct7;
  logic                 mem_we_height;
  logic                 mem_we_weight;
  logic [USER_BITS-1:0] mem_index;
  logic [31:0]          mem_wdata;
  logic                 alu_start;
  logic                 alu_sel_bmr;
  logic [6:0]           alu_funct7;
  logic                 alu_done;
  logic [31:0]          alu_result;
  logic                 res_valid;
  logic                 res_ready;
  logic [31:0]          res_data;
  logic                 res_err;
  logic                 busy;

  modport slave (
    input  in_valid, is_set_height, is_set_weight, is_calc_bmi, is_calc_bmr,
    input  rd, imm_ext, funct7, alu_done, alu_result, res_ready,
    output in_ready, mem_we_height, mem_we_weight, mem_index, mem_wdata,
    output alu_start, alu_sel_bmr, alu_funct7, res_valid, res_data, res_err, busy
  );

  modport master (
    output in_valid, is_set_height, is_set_weight, is_calc_bmi, is_calc_bmr,
    output rd, imm_ext, funct7, alu_done, alu_result, res_ready,
    input  in_ready, mem_we_height, mem_we_weight, mem_index, mem_wdata,
    input  alu_start, alu_sel_bmr, alu_funct7, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/health_exec_ctrl.sv
// Executes decoded health instructions: per-user height/weight writes tracked by a scoreboard,
// and BMI/BMR calculations launched on an external ALU with a bounded wait.
module health_exec_ctrl #(
  parameter int USER_BITS   = 5,
  parameter int ALU_TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  health_exec_ctrl_if.slave bus
);
  localparam int NUM_USERS = 2 ** USER_BITS;
  localparam int CNT_W     = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CHECK, S_LAUNCH, S_WAIT, S_RESP
  } state_t;

  typedef struct packed {
    logic                 set_h;
    logic                 set_w;
    logic                 bmi;
    logic                 bmr;
    logic [USER_BITS-1:0] rd;
    logic [31:0]          imm;
    logic [6:0]           f7;
  } instr_t;

  state_t               state_q, state_d;
  instr_t               ins_q, ins_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic [NUM_USERS-1:0] h_ok_q, h_ok_d;
  logic [NUM_USERS-1:0] w_ok_q, w_ok_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ins_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      h_ok_q     <= '0;
      w_ok_q     <= '0;
    end else begin
      state_q    <= state_d;
      ins_q      <= ins_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      h_ok_q     <= h_ok_d;
      w_ok_q     <= w_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ins_d      = ins_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    h_ok_d     = h_ok_q;
    w_ok_d     = w_ok_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ins_d = '{set_h: bus.is_set_height, set_w: bus.is_set_weight,
                    bmi: bus.is_calc_bmi, bmr: bus.is_calc_bmr,
                    rd: bus.rd, imm: bus.imm_ext, f7: bus.funct7};
          if (!$onehot({bus.is_set_height, bus.is_set_weight, bus.is_calc_bmi, bus.is_calc_bmr})) begin
            state_d    = S_RESP;
            res_err_d  = 1'b1;
            res_data_d = 32'd1;
          end else if (bus.is_set_height || bus.is_set_weight) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_WRITE: begin
        if (ins_q.set_h) h_ok_d[ins_q.rd] = 1'b1;
        if (ins_q.set_w) w_ok_d[ins_q.rd] = 1'b1;
        state_d = S_IDLE;
      end
      S_CHECK: begin
        if (h_ok_q[ins_q.rd] && w_ok_q[ins_q.rd]) begin
          state_d = S_LAUNCH;
        end else begin
          state_d    = S_RESP;
          res_err_d  = 1'b1;
          res_data_d = 32'd2;
        end
      end
      S_LAUNCH: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle beats the timeout.
        if (bus.alu_done) begin
          state_d    = S_RESP;
          res_err_d  = 1'b0;
          res_data_d = bus.alu_result;
        end else if (cnt_q == CNT_W'(ALU_TIMEOUT)) begin
          state_d    = S_RESP;
          res_err_d  = 1'b1;
          res_data_d = 32'd3;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data-path outputs come straight from the captured instruction, so they stay
  // stable for the whole operation and fall to zero with reset.
  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_we_height = (state_q == S_WRITE) && ins_q.set_h;
  assign bus.mem_we_weight = (state_q == S_WRITE) && ins_q.set_w;
  assign bus.mem_index     = ins_q.rd;
  assign bus.mem_wdata     = ins_q.imm;
  assign bus.alu_start     = (state_q == S_LAUNCH);
  assign bus.alu_sel_bmr   = ins_q.bmr;
  assign bus.alu_funct7    = ins_q.f7;
  assign bus.res_valid     = (state_q == S_RESP);
  assign bus.res_data      = res_data_q;
  assign bus.res_err       = res_err_q;
endmodule

// File: tb/tb_health_exec_ctrl.sv
// Transaction-level checker for health_exec_ctrl: a scoreboard model plus a per-cycle
// schedule of expected outputs, driven by directed and randomized instructions.
module tb_health_exec_ctrl;
  localparam int UB = 5;
  localparam int TO = 8;
  localparam int NU = 2 ** UB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  health_exec_ctrl_if #(.USER_BITS(UB)) bus ();
  health_exec_ctrl #(.USER_BITS(UB), .ALU_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit             in_ready, busy, we_h, we_w, alu_start, res_valid, res_err;
    logic [31:0]    res_data;
    bit             chk_idx, chk_wdata, chk_alu;
    logic [UB-1:0]  idx;
    logic [31:0]    wdata;
    bit             sel;
    logic [6:0]     f7;
  } exp_t;

  exp_t e;
  bit   chk_en = 1'b0;
  bit   h_ok[NU];
  bit   w_ok[NU];

  function automatic exp_t idle_exp();
    exp_t x;
    x = '{default: 0};
    x.in_ready = 1'b1;
    return x;
  endfunction

  function automatic exp_t busy_exp();
    exp_t x;
    x = '{default: 0};
    x.busy = 1'b1;
    return x;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", bus.in_ready, e.in_ready);
      chk("busy", bus.busy, e.busy);
      chk("mem_we_height", bus.mem_we_height, e.we_h);
      chk("mem_we_weight", bus.mem_we_weight, e.we_w);
      chk("alu_start", bus.alu_start, e.alu_start);
      chk("res_valid", bus.res_valid, e.res_valid);
      if (e.res_valid) begin
        chk("res_data", bus.res_data, e.res_data);
        chk("res_err", bus.res_err, e.res_err);
      end
      if (e.chk_idx)   chk("mem_index", bus.mem_index, e.idx);
      if (e.chk_wdata) chk("mem_wdata", bus.mem_wdata, e.wdata);
      if (e.chk_alu) begin
        chk("alu_sel_bmr", bus.alu_sel_bmr, e.sel);
        chk("alu_funct7", bus.alu_funct7, e.f7);
      end
    end
  end

  // Event monitor used by the literal latency and pulse-count checks.
  int cyc = 0, acc_cyc = 0, start_cyc = 0, lat = 0, wlat = 0;
  int n_start = 0, n_weh = 0, n_resp = 0;
  bit rv_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) acc_cyc <= cyc;
      if (bus.alu_start) begin
        start_cyc <= cyc;
        n_start   <= n_start + 1;
      end
      if (bus.mem_we_height) n_weh <= n_weh + 1;
      if (bus.res_valid && !rv_prev) begin
        n_resp <= n_resp + 1;
        lat    <= cyc - acc_cyc;
        wlat   <= cyc - start_cyc - 1;
      end
      rv_prev <= bus.res_valid;
    end else begin
      rv_prev <= 1'b0;
    end
  end

  logic [31:0] last_data;
  logic        last_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.in_valid      = 1'($urandom_range(0, 1));
    bus.is_set_height = 1'($urandom_range(0, 1));
    bus.is_set_weight = 1'($urandom_range(0, 1));
    bus.is_calc_bmi   = 1'($urandom_range(0, 1));
    bus.is_calc_bmr   = 1'($urandom_range(0, 1));
    bus.rd            = UB'($urandom);
    bus.imm_ext       = $urandom;
    bus.funct7        = 7'($urandom);
    bus.alu_done      = 1'($urandom_range(0, 1));
    bus.alu_result    = $urandom;
    bus.res_ready     = 1'($urandom_range(0, 1));
  endtask

  task automatic quiet();
    noise();
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  // stb = {set_height, set_weight, calc_bmi, calc_bmr}; done_k = WAIT cycle of alu_done (0: never);
  // abort_j > 0 asserts reset in that WAIT cycle.
  task automatic do_instr(input logic [3:0] stb, input logic [UB-1:0] rd, input logic [31:0] imm,
                          input logic [6:0] f7, input int done_k, input logic [31:0] result,
                          input int rdy_delay, input int abort_j);
    int          nstb;
    logic [31:0] rdata;
    logic        rerr;
    nstb = int'(stb[3]) + int'(stb[2]) + int'(stb[1]) + int'(stb[0]);
    e = idle_exp();
    noise();
    bus.in_valid      = 1'b1;
    {bus.is_set_height, bus.is_set_weight, bus.is_calc_bmi, bus.is_calc_bmr} = stb;
    bus.rd = rd; bus.imm_ext = imm; bus.funct7 = f7;
    step();
    if (nstb != 1) begin
      rdata = 32'd1; rerr = 1'b1;
    end else if (stb[3] || stb[2]) begin
      e = busy_exp();
      e.we_h = stb[3]; e.we_w = stb[2];
      e.chk_idx = 1'b1; e.idx = rd; e.chk_wdata = 1'b1; e.wdata = imm;
      if (stb[3]) h_ok[rd] = 1'b1;
      if (stb[2]) w_ok[rd] = 1'b1;
      noise();
      step();
      quiet();
      e = idle_exp();
      return;
    end else begin
      e = busy_exp();
      noise();
      step();
      if (!(h_ok[rd] && w_ok[rd])) begin
        rdata = 32'd2; rerr = 1'b1;
      end else begin
        e = busy_exp();
        e.alu_start = 1'b1;
        e.chk_idx = 1'b1; e.idx = rd; e.chk_alu = 1'b1; e.sel = stb[0]; e.f7 = f7;
        noise();
        step();
        for (int j = 1; j <= TO; j++) begin
          e.alu_start = 1'b0;
          noise();
          bus.alu_done   = (j == done_k);
          bus.alu_result = (j == done_k) ? result : $urandom;
          if (j == abort_j) begin
            chk_en = 1'b0;
            #2 reset = 1'b1;
            #1;
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_err", bus.res_err, 0);
            chk("rst_res_data", bus.res_data, 0);
            chk("rst_alu_start", bus.alu_start, 0);
            chk("rst_mem_index", bus.mem_index, 0);
            chk("rst_alu_sel", bus.alu_sel_bmr, 0);
            chk("rst_alu_funct7", bus.alu_funct7, 0);
            foreach (h_ok[u]) begin h_ok[u] = 1'b0; w_ok[u] = 1'b0; end
            quiet();
            repeat (2) step();
            reset = 1'b0;
            e = idle_exp();
            chk_en = 1'b1;
            return;
          end
          step();
          if (j == done_k) begin rdata = result; rerr = 1'b0; break; end
          if (j == TO)     begin rdata = 32'd3;  rerr = 1'b1; end
        end
      end
    end
    last_data = bus.res_data;
    last_err  = bus.res_err;
    for (int c = 0; c < 64; c++) begin
      e = busy_exp();
      e.res_valid = 1'b1; e.res_data = rdata; e.res_err = rerr;
      noise();
      bus.res_ready = (c >= rdy_delay);
      step();
      if (c >= rdy_delay) break;
    end
    quiet();
    e = idle_exp();
  endtask

  int weh0, st0, rs0;
  logic [3:0] stb;
  int pick;

  initial begin
    reset = 1'b1;
    quiet();
    e = idle_exp();
    foreach (h_ok[u]) begin h_ok[u] = 1'b0; w_ok[u] = 1'b0; end
    #1;
    chk("init_in_ready", bus.in_ready, 1);
    chk("init_busy", bus.busy, 0);
    chk("init_res_valid", bus.res_valid, 0);
    chk("init_mem_we_height", bus.mem_we_height, 0);
    chk("init_mem_wdata", bus.mem_wdata, 0);
    repeat (2) step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    weh0 = n_weh; rs0 = n_resp;
    do_instr(4'b1000, 5'd3, 32'd170, 7'd0, 0, 0, 0, 0);
    step();
    chk("height_pulses", n_weh - weh0, 1);
    chk("height_no_resp", n_resp - rs0, 0);

    do_instr(4'b0100, 5'd3, 32'd65, 7'd0, 0, 0, 0, 0);
    do_instr(4'b0010, 5'd3, 32'd0, 7'h5e, 1, 32'd22, 3, 0);
    chk("bmi_data", last_data, 22);
    chk("bmi_err", last_err, 0);
    chk("bmi_latency", lat, 4);

    st0 = n_start;
    do_instr(4'b1000, 5'd7, 32'd180, 7'd0, 0, 0, 0, 0);
    do_instr(4'b0001, 5'd7, 32'd0, 7'h45, 1, 32'd1500, 1, 0);
    chk("bmr_nowt_data", last_data, 2);
    chk("bmr_nowt_err", last_err, 1);
    chk("bmr_nowt_nostart", n_start - st0, 0);

    do_instr(4'b0110, 5'd3, 32'd0, 7'd0, 0, 0, 0, 0);
    chk("illegal2_data", last_data, 1);
    chk("illegal2_err", last_err, 1);
    do_instr(4'b0000, 5'd3, 32'd0, 7'd0, 0, 0, 2, 0);
    chk("illegal0_data", last_data, 1);

    do_instr(4'b0010, 5'd3, 32'd0, 7'd9, 0, 0, 0, 0);
    chk("timeout_data", last_data, 3);
    chk("timeout_err", last_err, 1);
    chk("timeout_cycles", wlat, TO);
    do_instr(4'b0001, 5'd3, 32'd0, 7'd9, TO, 32'd1777, 0, 0);
    chk("lastcycle_data", last_data, 1777);
    chk("lastcycle_err", last_err, 0);
    chk("lastcycle_cycles", wlat, TO);

    do_instr(4'b0010, 5'd3, 32'd0, 7'd1, 0, 0, 0, 3);
    do_instr(4'b0010, 5'd3, 32'd0, 7'd1, 1, 32'd22, 0, 0);
    chk("post_reset_data", last_data, 2);
    chk("post_reset_err", last_err, 1);

    for (int t = 0; t < 150; t++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: stb = 4'b1000;
        3, 4, 5: stb = 4'b0100;
        6:       stb = 4'b0010;
        7:       stb = 4'b0001;
        8:       stb = 4'($urandom);
        default: stb = ($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0001;
      endcase
      do_instr(stb, UB'($urandom_range(0, 5)), $urandom, 7'($urandom),
               $urandom_range(0, TO), $urandom, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) step();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
